board_adder_bist: RTL and testbench
===================================

# board_adder_bist

Built-in self-test sequencer for the board's two pin-level adders: the 3-bit pair (4-bit sum) and the 4-bit pair (5-bit sum). It sweeps every input combination through the adders under test and compares each returned sum against an internal golden sum. It counts mismatches, captures the first failing vector and reports pass/fail through a start/busy/done handshake. It sits between the board-test top level and the adder pins, replacing manual switch stimulus.

## Interface
- SETTLE, default 2: extra cycles each vector is held before its sum is sampled; legal range 1–15.
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low
- start  in  1  run request, sampled in IDLE or DONE
- abort  in  1  synchronous abort, sampled while busy
- add_a, add_b  out  3 each  stimulus to 3-bit adder
- sum_ab  in  4  3-bit adder result
- add_c, add_d  out  4 each  stimulus to 4-bit adder
- sum_cd  in  5  4-bit adder result
- busy  out  1  run in progress
- done  out  1  run completed, held until next start
- pass  out  1  done and zero mismatches
- err_count  out  9  mismatching vectors this run (max 320)
- fail_valid  out  1  first-failure capture registers are loaded
- fail_phase  out  1  0 = 3-bit adder, 1 = 4-bit adder
- fail_a, fail_b  out  4 each  failing operands (3-bit values zero-extended)
- fail_sum  out  5  observed sum at first failure (sum_ab zero-extended)

## Operation
- States:
  - IDLE → P3 on start.
  - P3 → P4 after vector 63 is sampled.
  - P4 → DONE after vector 255 is sampled.
  - DONE → P3 on start.
  - P3/P4 → IDLE on abort.
- Vector order:
  - P3: index i = 0..63, with add_a = i[5:3] and add_b = i[2:0]; add_c = add_d = 0.
  - P4: index j = 0..255, with add_c = j[7:4] and add_d = j[3:0]; add_a = add_b = 0.
- Check rules:
  - P3 expects sum_ab == add_a + add_b at 4-bit width.
  - P4 expects sum_cd == add_c + add_d at 5-bit width.
  - Both are exact compares with no masking.
- Mismatch handling:
  - Each mismatch increments err_count by 1. The count cannot overflow.
  - On the first mismatch of a run, fail_valid is set and fail_phase, fail_a, fail_b and fail_sum are loaded. They are not updated again until the next start.
- start:
  - In IDLE or DONE, start clears err_count, fail_* and done, then enters P3.
  - start while busy is ignored.
- abort:
  - In P3/P4, abort returns to IDLE on the next edge. busy = 0, done = 0, stimulus outputs = 0; err_count and fail_* are retained.
  - Simultaneous start and abort in IDLE: abort wins and the block stays IDLE.
- pass = done && (err_count == 0). It is 0 in all other states.
- sum inputs are sampled directly with no synchronizer. SETTLE covers pin round-trip delay.

## Timing
- Reset values: every output is 0 and the state is IDLE. Reset is asserted asynchronously at any point, including mid-run.
- start is sampled at edge E. busy = 1 and vector 0 is driven from cycle E+1.
- Each vector is driven for exactly SETTLE+1 cycles. Its sum is sampled at the edge that ends the last of those cycles, and the next vector appears in the following cycle.
- There is no gap between P3 and P4.
- busy is high for exactly 320·(SETTLE+1) cycles; this is 960 cycles for SETTLE = 2.
- err_count and fail_* update at the sample edge.
- done rises, and busy falls, in the same cycle.

## Structure
- Shared package board_test_pkg holds:
  - state enum (IDLE, P3, P4, DONE)
  - N3 = 64 and N4 = 256
  - widths ERR_W = 9 and SUM_W = 5
- One sub-module, bist_vector_gen, holds:
  - the settle down-counter, the vector index counter and the phase bit
  - outputs: the current operands, a one-cycle sample strobe and a last-vector flag
- The top level holds the FSM, golden compare, error counter and failure capture.

## Test plan
All scenarios use SETTLE = 2.
- Ideal adder model, single start pulse → busy high for 960 cycles, then done = 1, pass = 1, err_count = 0, fail_valid = 0.
- sum_ab bit 0 stuck at 0 → err_count = 32, fail_phase = 0, fail_a = 0, fail_b = 1, fail_sum = 0, pass = 0.
- sum_cd bit 4 stuck at 0 → err_count = 120, fail_phase = 1, fail_a = 1, fail_b = 15, fail_sum = 0.
- abort in cycle 100 of a run → next cycle busy = 0, done = 0, all stimulus = 0. A following start clears err_count and completes normally.
- reset pulsed low mid-P4 → all outputs 0 immediately, state IDLE after release. No activity until start.
- start held high throughout → ignored while busy. The run restarts the cycle after done and done is high for exactly 1 cycle.

Source files
------------

// File: rtl/board_test_pkg.sv
// rtl/board_test_pkg.sv - shared types and sizes for the board adder self-test
package board_test_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    P3   = 2'd1,
    P4   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int N3    = 64;
  localparam int N4    = 256;
  localparam int ERR_W = 9;
  localparam int SUM_W = 5;

endpackage

// File: rtl/bist_vector_gen.sv
// rtl/bist_vector_gen.sv - settle timer, vector index and phase for the adder sweep
module bist_vector_gen
  import board_test_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       run,
  output logic [2:0] op_a,
  output logic [2:0] op_b,
  output logic [3:0] op_c,
  output logic [3:0] op_d,
  output logic       phase,
  output logic       sample,
  output logic       last
);

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);
  localparam logic [7:0] LAST3      = 8'(N3 - 1);
  localparam logic [7:0] LAST4      = 8'(N4 - 1);

  logic [3:0] settle_cnt;
  logic [7:0] idx;

  // The sum is taken on the final cycle of each vector's hold window.
  assign sample = run && (settle_cnt == 4'd0);
  assign last   = phase ? (idx == LAST4) : (idx == LAST3);

  // Operands are forced to zero whenever no run is in progress, and the idle adder sees zeros.
  assign op_a = (run && !phase) ? idx[5:3] : 3'd0;
  assign op_b = (run && !phase) ? idx[2:0] : 3'd0;
  assign op_c = (run &&  phase) ? idx[7:4] : 4'd0;
  assign op_d = (run &&  phase) ? idx[3:0] : 4'd0;

  // Count down each hold window, then step the index; wrap into the 4-bit phase after vector 63.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      settle_cnt <= 4'd0;
      idx        <= 8'd0;
      phase      <= 1'b0;
    end else if (load) begin
      settle_cnt <= SETTLE_CNT;
      idx        <= 8'd0;
      phase      <= 1'b0;
    end else if (run) begin
      if (settle_cnt == 4'd0) begin
        settle_cnt <= SETTLE_CNT;
        if (last) begin
          idx   <= 8'd0;
          phase <= ~phase;
        end else begin
          idx <= idx + 8'd1;
        end
      end else begin
        settle_cnt <= settle_cnt - 4'd1;
      end
    end
  end

endmodule

// File: rtl/board_adder_bist.sv
// rtl/board_adder_bist.sv - self-test sequencer sweeping the 3-bit and 4-bit board adders
module board_adder_bist
  import board_test_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic [2:0]       add_a,
  output logic [2:0]       add_b,
  input  logic [3:0]       sum_ab,
  output logic [3:0]       add_c,
  output logic [3:0]       add_d,
  input  logic [4:0]       sum_cd,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic             fail_phase,
  output logic [3:0]       fail_a,
  output logic [3:0]       fail_b,
  output logic [SUM_W-1:0] fail_sum
);

  state_t           state;
  logic             go;
  logic             phase;
  logic             sample;
  logic             last;
  logic             mismatch;
  logic [3:0]       golden_ab;
  logic [SUM_W-1:0] golden_cd;

  // Abort beats a coincident start while idle; a finished run restarts on start alone.
  assign go = ((state == IDLE) && start && !abort) || ((state == DONE) && start);

  bist_vector_gen #(
    .SETTLE (SETTLE)
  ) u_vec (
    .clk    (clk),
    .reset  (reset),
    .load   (go),
    .run    (busy),
    .op_a   (add_a),
    .op_b   (add_b),
    .op_c   (add_c),
    .op_d   (add_d),
    .phase  (phase),
    .sample (sample),
    .last   (last)
  );

  // Golden sums at the adders' native widths; compares are exact.
  assign golden_ab = {1'b0, add_a} + {1'b0, add_b};
  assign golden_cd = {1'b0, add_c} + {1'b0, add_d};
  assign mismatch  = phase ? (sum_cd != golden_cd) : (sum_ab != golden_ab);

  assign pass = done && (err_count == '0);

  // Run sequencing, error counting and first-failure capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_phase <= 1'b0;
      fail_a     <= 4'd0;
      fail_b     <= 4'd0;
      fail_sum   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (go) begin
            state      <= P3;
            busy       <= 1'b1;
            done       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_phase <= 1'b0;
            fail_a     <= 4'd0;
            fail_b     <= 4'd0;
            fail_sum   <= '0;
          end
        end
        P3, P4: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end else if (sample) begin
            if (mismatch) begin
              if (err_count != '1) err_count <= err_count + ERR_W'(1);
              if (!fail_valid) begin
                fail_valid <= 1'b1;
                fail_phase <= phase;
                fail_a     <= phase ? add_c  : {1'b0, add_a};
                fail_b     <= phase ? add_d  : {1'b0, add_b};
                fail_sum   <= phase ? sum_cd : {1'b0, sum_ab};
              end
            end
            if (last) begin
              if (state == P3) begin
                state <= P4;
              end else begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_adder_bist.sv
// tb/tb_board_adder_bist.sv - scoreboard bench for the board adder self-test sequencer
module tb_board_adder_bist;

  logic       clk = 1'b0;
  logic       reset, start, abort;
  logic [2:0] add_a, add_b;
  logic [3:0] add_c, add_d, sum_ab;
  logic [4:0] sum_cd;
  logic       busy, done, pass;
  logic [8:0] err_count;
  logic       fail_valid, fail_phase;
  logic [3:0] fail_a, fail_b;
  logic [4:0] fail_sum;

  typedef struct {
    int cycles;
    int err;
    int pss;
    int fv;
    int fph;
    int fa;
    int fb;
    int fs;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   fault = 0;

  always #5 clk = ~clk;

  // Board adder model; fault 1 sticks sum_ab[0] low, fault 2 sticks sum_cd[4] low.
  assign sum_ab = ({1'b0, add_a} + {1'b0, add_b}) & ((fault == 1) ? 4'he : 4'hf);
  assign sum_cd = ({1'b0, add_c} + {1'b0, add_d}) & ((fault == 2) ? 5'h0f : 5'h1f);

  board_adder_bist #(.SETTLE(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .add_a      (add_a),
    .add_b      (add_b),
    .sum_ab     (sum_ab),
    .add_c      (add_c),
    .add_d      (add_d),
    .sum_cd     (sum_cd),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .fail_valid (fail_valid),
    .fail_phase (fail_phase),
    .fail_a     (fail_a),
    .fail_b     (fail_b),
    .fail_sum   (fail_sum)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic push_exp(input int err, input int pss, input int fv, input int fph,
                          input int fa, input int fb, input int fs);
    exp_t e;
    e.cycles = 960; e.err = err; e.pss = pss; e.fv = fv;
    e.fph = fph; e.fa = fa; e.fb = fb; e.fs = fs;
    sb_q.push_back(e);
  endtask

  task automatic start_pulse();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Monitor: checks the vector order every busy cycle and pops an expectation at each done.
  initial begin
    int   cyc;
    int   k;
    int   j;
    int   ea, eb, ec, ed;
    bit   seq_bad;
    logic done_d;
    exp_t e;
    cyc = 0; seq_bad = 0; done_d = 1'b0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        k = cyc / 3;
        if (k < 64) begin
          ea = k / 8; eb = k % 8; ec = 0; ed = 0;
        end else begin
          j = k - 64;
          ea = 0; eb = 0; ec = j / 16; ed = j % 16;
        end
        if (add_a !== 3'(ea) || add_b !== 3'(eb) || add_c !== 4'(ec) || add_d !== 4'(ed))
          seq_bad = 1;
        cyc++;
      end else if (done === 1'b1 && done_d !== 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("busy_cycles", cyc, e.cycles);
          check("vector_seq", 32'(seq_bad), 32'd0);
          check("err_count", 32'(err_count), e.err);
          check("pass", 32'(pass), e.pss);
          check("fail_valid", 32'(fail_valid), e.fv);
          check("fail_phase", 32'(fail_phase), e.fph);
          check("fail_a", 32'(fail_a), e.fa);
          check("fail_b", 32'(fail_b), e.fb);
          check("fail_sum", 32'(fail_sum), e.fs);
        end
        cyc = 0; seq_bad = 0;
      end else begin
        cyc = 0; seq_bad = 0;
      end
      done_d = done;
    end
  end

  // Global time limit so the bench always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus.
  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; fault = 0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {busy, done, pass, fail_valid, fail_phase}, 32'd0);
    check("rst_regs", {err_count, fail_a, fail_b, fail_sum}, 32'd0);
    check("rst_stim", {add_a, add_b, add_c, add_d}, 32'd0);
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_quiet", {busy, done}, 32'd0);

    // Ideal adders.
    fault = 0;
    push_exp(0, 1, 0, 0, 0, 0, 0);
    start_pulse();
    wait_done(1200, "ideal");

    // sum_ab[0] stuck low: 32 odd sums, first at a=0 b=1.
    fault = 1;
    push_exp(32, 0, 1, 0, 0, 1, 0);
    start_pulse();
    wait_done(1200, "ab_bit0");

    // sum_cd[4] stuck low: 120 sums >= 16, first at c=1 d=15.
    fault = 2;
    push_exp(120, 0, 1, 1, 1, 15, 0);
    start_pulse();
    wait_done(1200, "cd_bit4");

    // Abort during cycle 100: vectors 0..32 were sampled, 16 of them odd.
    fault = 1;
    start_pulse();
    repeat (99) @(negedge clk);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    check("abort_busy_done", {busy, done}, 32'd0);
    check("abort_stim", {add_a, add_b, add_c, add_d}, 32'd0);
    check("abort_err_kept", 32'(err_count), 32'd16);
    check("abort_fail_kept", {fail_valid, fail_b}, {27'd0, 1'b1, 4'd1});
    // Start and abort together in IDLE: stays idle.
    @(negedge clk) begin start = 1'b1; abort = 1'b1; end
    @(negedge clk) begin start = 1'b0; abort = 1'b0; end
    check("start_abort_idle", 32'(busy), 32'd0);
    fault = 0;
    push_exp(0, 1, 0, 0, 0, 0, 0);
    start_pulse();
    wait_done(1200, "after_abort");

    // Reset mid-P4.
    start_pulse();
    repeat (400) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_ctrl", {busy, done, pass, fail_valid, fail_phase}, 32'd0);
    check("midrst_regs", {err_count, fail_a, fail_b, fail_sum}, 32'd0);
    check("midrst_stim", {add_a, add_b, add_c, add_d}, 32'd0);
    @(negedge clk) reset = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_idle", {busy, done, add_a, add_b, add_c, add_d}, 32'd0);

    // start held high: ignored while busy, done lasts one cycle, run restarts.
    push_exp(0, 1, 0, 0, 0, 0, 0);
    push_exp(0, 1, 0, 0, 0, 0, 0);
    @(negedge clk) start = 1'b1;
    wait_done(1200, "held_first");
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(1200, "held_second");

    repeat (5) @(negedge clk);
    check("sb_drained", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
